// File: rtl/tone_pkg.sv
// Shared definitions for the tone sequencer.
//   FREQ_HZ      : tone frequency per note code 0..88 (31 Hz * 2^(n/12), rounded)
//   MAX_TONE     : highest code that selects its own table entry
//   DEFAULT_NOTE : table entry used for codes 89..126
//   REST_NOTE    : code that keeps the output low for the note's duration
//   state_t      : sequencer state encoding
//   half_cycles  : clock cycles per half period minus one, for a given tone
package tone_pkg;

  localparam int unsigned NUM_TONES    = 89;
  localparam logic [6:0]  MAX_TONE     = 7'd88;
  localparam logic [6:0]  DEFAULT_NOTE = 7'd61;
  localparam logic [6:0]  REST_NOTE    = 7'd127;

  // Note 61 is pinned at 1050 Hz; it doubles as the default tone.
  localparam int unsigned FREQ_HZ [NUM_TONES] = '{
      31,   33,   35,   37,   39,   41,   44,   46,   49,   52,   55,   59,
      62,   66,   70,   74,   78,   83,   88,   93,   98,  104,  110,  117,
     124,  131,  139,  147,  156,  166,  175,  186,  197,  209,  221,  234,
     248,  263,  278,  295,  312,  331,  351,  372,  394,  417,  442,  468,
     496,  525,  557,  590,  625,  662,  701,  743,  787,  834,  884,  936,
     992, 1050, 1113, 1180, 1250, 1324, 1403, 1486, 1575, 1668, 1768, 1873,
    1984, 2102, 2227, 2359, 2500, 2648, 2806, 2973, 3149, 3337, 3535, 3745,
    3968, 4204, 4454, 4719, 4999
  };

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

  // round(clk_hz / (2 * f_hz)) - 1
  function automatic int unsigned half_cycles(input int unsigned clk_hz,
                                              input int unsigned f_hz);
    return (clk_hz + f_hz) / (2 * f_hz) - 1;
  endfunction

endpackage

// File: rtl/tone_fifo.sv
// Note queue: synchronous FIFO with show-ahead read data.
//   clk, rst : clock, synchronous active-high reset
//   clr      : discard all entries (wins over a same-cycle push)
//   push     : write wdata when not full (a same-cycle pop never frees room)
//   pop      : advance past the head entry when not empty
//   rdata    : current head entry
//   level    : number of stored entries; full/empty flags derived from it
module tone_fifo
  import tone_pkg::*;
#(
  parameter int unsigned WIDTH = 23,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full & ~clr;
  assign do_pop  = pop & ~empty & ~clr;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/tone_seq.sv
// Tone sequencer: plays queued (note, duration) entries as a square wave.
//   clk, rst          : clock, synchronous active-high reset
//   en                : play enable; low pauses the current note
//   flush             : drop the queue and the current note
//   in_valid/in_ready : note entry handshake (in_note code, in_dur in ms)
//   buz               : square-wave output
//   busy              : high while a note is playing
//   level             : number of queued entries
//   done              : one-cycle pulse after the last queued note ends
module tone_seq
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ = 24_000_000,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DUR_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [6:0]             in_note,
  input  logic [DUR_W-1:0]       in_dur,
  output logic                   buz,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   done
);

  localparam int unsigned TICK_CYC = CLK_HZ / 1000;
  localparam int unsigned TICK_W   = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int unsigned HALF_MAX = half_cycles(CLK_HZ, FREQ_HZ[0]);
  localparam int unsigned HALF_W   = (HALF_MAX > 0) ? $clog2(HALF_MAX + 1) : 1;
  localparam int unsigned FW       = 7 + DUR_W;

  state_t            state;
  state_t            state_n;
  logic [6:0]        note_q;
  logic [DUR_W-1:0]  rem;
  logic [TICK_W-1:0] tick_cnt;
  logic [HALF_W-1:0] tone_cnt;
  logic [HALF_W-1:0] half_sel;
  logic [HALF_W-1:0] half_rom [NUM_TONES];
  logic [6:0]        note_idx;
  logic              tick_wrap;
  logic              pop;
  logic              note_end;
  logic              done_n;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FW-1:0]     head;
  logic [6:0]        head_note;
  logic [DUR_W-1:0]  head_dur;

  // Half-period table resolved at elaboration for this clock rate.
  for (genvar g = 0; g < NUM_TONES; g++) begin : g_half
    assign half_rom[g] = HALF_W'(half_cycles(CLK_HZ, FREQ_HZ[g]));
  end

  assign note_idx  = (note_q > MAX_TONE) ? DEFAULT_NOTE : note_q;
  assign half_sel  = half_rom[note_idx];
  assign tick_wrap = (tick_cnt == TICK_W'(TICK_CYC - 1));
  assign head_note = head[FW-1:DUR_W];
  assign head_dur  = head[DUR_W-1:0];
  assign in_ready  = ~fifo_full;
  assign busy      = (state == ST_PLAY);

  tone_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (in_valid),
    .pop   (pop),
    .wdata ({in_note, in_dur}),
    .rdata (head),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    pop      = 1'b0;
    note_end = 1'b0;
    done_n   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (en && !fifo_empty) begin
          pop     = 1'b1;
          state_n = ST_PLAY;
        end
      end
      ST_PLAY: begin
        // Remaining duration of 1 at a tick wrap means it reaches 0 now.
        if (en && tick_wrap && rem == DUR_W'(1)) begin
          note_end = 1'b1;
          if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (flush) begin
      state_n  = ST_IDLE;
      pop      = 1'b0;
      note_end = 1'b0;
      done_n   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done <= 1'b0;
    end else begin
      done <= done_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      note_q   <= '0;
      rem      <= '0;
      tick_cnt <= '0;
      tone_cnt <= '0;
      buz      <= 1'b0;
    end else if (pop) begin
      note_q   <= head_note;
      rem      <= (head_dur == '0) ? DUR_W'(1) : head_dur;
      tick_cnt <= '0;
      tone_cnt <= '0;
      buz      <= 1'b0;
    end else if (note_end) begin
      rem      <= '0;
      tick_cnt <= '0;
      tone_cnt <= '0;
      buz      <= 1'b0;
    end else if (state == ST_PLAY && en) begin
      tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
      if (tick_wrap) rem <= rem - 1'b1;
      if (note_q == REST_NOTE) begin
        buz      <= 1'b0;
        tone_cnt <= '0;
      end else if (tone_cnt == half_sel) begin
        buz      <= ~buz;
        tone_cnt <= '0;
      end else begin
        tone_cnt <= tone_cnt + 1'b1;
      end
    end else begin
      // Idle or paused: counters hold, output parks low.
      buz <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tone_seq.sv
// Directed self-checking bench for tone_seq (2 MHz clock, 4-entry queue).
module tb_tone_seq;

  logic        clk;
  logic        rst;
  logic        en;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_note;
  logic [15:0] in_dur;
  logic        buz;
  logic        busy;
  logic [2:0]  level;
  logic        done;

  int checks;
  int failures;

  int obs_tr [32];
  int obs_tr_n;
  int obs_busy_cnt;
  int obs_busy_runs;
  int obs_done_cnt;
  int obs_done_rel;
  bit obs_timeout;
  logic obs_buz_end;

  tone_seq #(
    .CLK_HZ (2_000_000),
    .DEPTH  (4),
    .DUR_W  (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_note  (in_note),
    .in_dur   (in_dur),
    .buz      (buz),
    .busy     (busy),
    .level    (level),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; flush = 1'b0; in_valid = 1'b0; in_note = '0; in_dur = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_one(input logic [6:0] note, input logic [15:0] dur);
    in_valid = 1'b1; in_note = note; in_dur = dur;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Records buz transitions and done pulses relative to the first busy sample.
  task automatic observe(input int max_cycles);
    bit seen;
    logic prev_buz;
    logic prev_busy;
    int rel;
    int tail;
    obs_tr_n = 0; obs_busy_cnt = 0; obs_busy_runs = 0; obs_done_cnt = 0;
    obs_done_rel = -1; obs_timeout = 1'b1;
    seen = 1'b0; prev_buz = buz; prev_busy = 1'b0; rel = 0; tail = 0;
    for (int k = 0; k < max_cycles; k++) begin
      @(negedge clk);
      if (busy && !seen) seen = 1'b1;
      if (seen) begin
        if (busy) obs_busy_cnt++;
        if (busy && !prev_busy) obs_busy_runs++;
        if (buz !== prev_buz && obs_tr_n < 32) begin
          obs_tr[obs_tr_n] = rel;
          obs_tr_n++;
        end
        if (done) begin
          obs_done_cnt++;
          obs_done_rel = rel;
        end
        if (!busy) tail++;
        if (tail == 20) begin
          obs_timeout = 1'b0;
          break;
        end
        rel++;
      end
      prev_buz = buz;
      prev_busy = busy;
    end
    obs_buz_end = buz;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; flush = 1'b0; in_valid = 1'b0; in_note = '0; in_dur = '0;
    repeat (2) @(negedge clk);
    checks++; if (buz !== 1'b0) begin failures++; $display("FAIL reset_buz got=%b exp=0", buz); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single_tone();
    do_reset();
    en = 1'b1;
    fork
      observe(6000);
      push_one(7'd88, 16'd1);
    join
    checks++; if (obs_timeout !== 1'b0) begin failures++; $display("FAIL single_timeout got=%b exp=0", obs_timeout); end
    checks++; if (obs_busy_cnt !== 2000) begin failures++; $display("FAIL single_busy_cycles got=%0d exp=2000", obs_busy_cnt); end
    checks++; if (obs_tr_n !== 10) begin failures++; $display("FAIL single_transitions got=%0d exp=10", obs_tr_n); end
    for (int i = 0; i < 10 && i < obs_tr_n; i++) begin
      checks++;
      if (obs_tr[i] !== 200 * (i + 1)) begin
        failures++; $display("FAIL single_edge%0d got=%0d exp=%0d", i, obs_tr[i], 200 * (i + 1));
      end
    end
    checks++; if (obs_done_cnt !== 1) begin failures++; $display("FAIL single_done_count got=%0d exp=1", obs_done_cnt); end
    checks++; if (obs_done_rel !== 2000) begin failures++; $display("FAIL single_done_time got=%0d exp=2000", obs_done_rel); end
    checks++; if (obs_buz_end !== 1'b0) begin failures++; $display("FAIL single_buz_after got=%b exp=0", obs_buz_end); end
  endtask

  task automatic test_dur_zero();
    do_reset();
    en = 1'b1;
    fork
      observe(6000);
      push_one(7'd88, 16'd0);
    join
    checks++; if (obs_busy_cnt !== 2000) begin failures++; $display("FAIL dur0_busy_cycles got=%0d exp=2000", obs_busy_cnt); end
    checks++; if (obs_done_cnt !== 1) begin failures++; $display("FAIL dur0_done_count got=%0d exp=1", obs_done_cnt); end
  endtask

  task automatic test_back_to_back();
    int exp_tr [6];
    exp_tr = '{952, 1904, 2856, 3808, 6952, 7904};
    do_reset();
    en = 1'b1;
    fork
      observe(12000);
      begin
        push_one(7'd61, 16'd2);
        push_one(7'd127, 16'd1);
        push_one(7'd100, 16'd1);
      end
    join
    checks++; if (obs_timeout !== 1'b0) begin failures++; $display("FAIL seq_timeout got=%b exp=0", obs_timeout); end
    checks++; if (obs_busy_cnt !== 8000) begin failures++; $display("FAIL seq_busy_cycles got=%0d exp=8000", obs_busy_cnt); end
    checks++; if (obs_busy_runs !== 1) begin failures++; $display("FAIL seq_gapless got=%0d exp=1", obs_busy_runs); end
    checks++; if (obs_tr_n !== 6) begin failures++; $display("FAIL seq_transitions got=%0d exp=6", obs_tr_n); end
    for (int i = 0; i < 6 && i < obs_tr_n; i++) begin
      checks++;
      if (obs_tr[i] !== exp_tr[i]) begin
        failures++; $display("FAIL seq_edge%0d got=%0d exp=%0d", i, obs_tr[i], exp_tr[i]);
      end
    end
    checks++; if (obs_done_cnt !== 1) begin failures++; $display("FAIL seq_done_count got=%0d exp=1", obs_done_cnt); end
    checks++; if (obs_done_rel !== 8000) begin failures++; $display("FAIL seq_done_time got=%0d exp=8000", obs_done_rel); end
  endtask

  task automatic test_fifo_full();
    logic exp_rdy;
    do_reset();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_note = 7'(i + 10); in_dur = 16'd1;
      exp_rdy = (i < 4);
      checks++; if (in_ready !== exp_rdy) begin failures++; $display("FAIL full_ready%0d got=%b exp=%b", i, in_ready, exp_rdy); end
      checks++; if (level !== 3'(i)) begin failures++; $display("FAIL full_level%0d got=%0d exp=%0d", i, level, i); end
      if (i < 4) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    checks++; if (level !== 3'd4) begin failures++; $display("FAIL full_held_level got=%0d exp=4", level); end
    en = 1'b1;
    @(negedge clk);
    checks++; if (level !== 3'd3) begin failures++; $display("FAIL full_pop_level got=%0d exp=3", level); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL full_pop_ready got=%b exp=1", in_ready); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL full_pop_busy got=%b exp=1", busy); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (level !== 3'd4) begin failures++; $display("FAIL full_fifth_level got=%0d exp=4", level); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_fifth_ready got=%b exp=0", in_ready); end
  endtask

  task automatic test_pause();
    int exp_tr [10];
    exp_tr = '{200, 400, 600, 701, 1300, 1500, 1700, 1900, 2100, 2300};
    do_reset();
    en = 1'b1;
    fork
      observe(8000);
      begin
        push_one(7'd88, 16'd1);
        for (int i = 0; i < 50 && !busy; i++) @(negedge clk);
        repeat (700) @(negedge clk);
        en = 1'b0;
        repeat (500) @(negedge clk);
        en = 1'b1;
      end
    join
    checks++; if (obs_timeout !== 1'b0) begin failures++; $display("FAIL pause_timeout got=%b exp=0", obs_timeout); end
    checks++; if (obs_busy_cnt !== 2500) begin failures++; $display("FAIL pause_busy_cycles got=%0d exp=2500", obs_busy_cnt); end
    checks++; if (obs_tr_n !== 10) begin failures++; $display("FAIL pause_transitions got=%0d exp=10", obs_tr_n); end
    for (int i = 0; i < 10 && i < obs_tr_n; i++) begin
      checks++;
      if (obs_tr[i] !== exp_tr[i]) begin
        failures++; $display("FAIL pause_edge%0d got=%0d exp=%0d", i, obs_tr[i], exp_tr[i]);
      end
    end
    checks++; if (obs_done_rel !== 2500) begin failures++; $display("FAIL pause_done_time got=%0d exp=2500", obs_done_rel); end
  endtask

  task automatic test_flush();
    int busy_seen;
    int done_seen;
    do_reset();
    en = 1'b1;
    push_one(7'd88, 16'd5);
    push_one(7'd88, 16'd5);
    push_one(7'd88, 16'd5);
    repeat (300) @(negedge clk);
    checks++; if (level !== 3'd2) begin failures++; $display("FAIL flush_pre_level got=%0d exp=2", level); end
    flush = 1'b1; in_valid = 1'b1; in_note = 7'd5; in_dur = 16'd1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL flush_level got=%0d exp=0", level); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", busy); end
    checks++; if (buz !== 1'b0) begin failures++; $display("FAIL flush_buz got=%b exp=0", buz); end
    busy_seen = 0; done_seen = 0;
    for (int i = 0; i < 3000; i++) begin
      if (busy) busy_seen++;
      if (done) done_seen++;
      @(negedge clk);
    end
    checks++; if (done_seen !== 0) begin failures++; $display("FAIL flush_no_done got=%0d exp=0", done_seen); end
    checks++; if (busy_seen !== 0) begin failures++; $display("FAIL flush_stays_idle got=%0d exp=0", busy_seen); end
  endtask

  task automatic test_reset_mid_note();
    int busy_seen;
    do_reset();
    en = 1'b1;
    push_one(7'd88, 16'd5);
    repeat (300) @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_note = 7'd40; in_dur = 16'd1;
    @(negedge clk);
    checks++; if (buz !== 1'b0) begin failures++; $display("FAIL rstmid_buz got=%b exp=0", buz); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", done); end
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL rstmid_level got=%0d exp=0", level); end
    rst = 1'b0; in_valid = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    checks++; if (busy_seen !== 0) begin failures++; $display("FAIL rstmid_not_stored got=%0d exp=0", busy_seen); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single_tone();
    test_dur_zero();
    test_back_to_back();
    test_fifo_full();
    test_pause();
    test_flush();
    test_reset_mid_note();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
